// File: rtl/uart_packet_parser.sv
// uart_packet_parser
//   Frames the raw uart_rx byte stream into {opcode, reserved, len_lo, len_hi, payload...}
//   packets. len is the little-endian total byte count including the 4-byte header.
//   Emits a one-cycle header pulse per packet. Payload bytes then leave on a valid/ready
//   stream through a single output register, with a last flag on the final byte.
//
//   Handshakes (both streams): a byte moves on a rising edge where valid and ready are both
//   high. A producer holds valid and data steady until that edge. Ready may depend
//   combinationally on the consumer's ready, but never on the producer's valid.
//
//   Optional feature: define PKT_TIMEOUT_EN to abort packets that stall mid-frame for
//   TIMEOUT_CYCLES cycles. The abort raises err_code 2'b10. Without the macro a stalled
//   packet waits indefinitely and no timeout logic is built.
module uart_packet_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        hdr_valid_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] payload_len_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        data_last_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD
  } state_e;

  // A timeout shorter than two cycles would abort every packet on its first gap.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q;
  logic [7:0]  opcode_pend_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] payload_len_q;
  logic [15:0] remaining_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        data_last_q;
  logic        hdr_valid_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        rx_ready;
  logic        accept;
  logic        pop;
  logic        timeout_hit;
  logic [15:0] len_full;

  // Header bytes are always taken. The opcode of the next packet and every payload byte
  // need space in the output register: either it is empty or it is drained this cycle.
  always_comb begin
    rx_ready = 1'b1;
    if (state_q == S_IDLE || state_q == S_PAYLOAD) begin
      rx_ready = !data_valid_q || data_ready_i;
    end
  end

  assign accept   = rx_valid_i && rx_ready;
  assign pop      = data_valid_q && data_ready_i;
  assign len_full = {rx_data_i, len_lo_q};

`ifdef PKT_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // The abort fires on the last idle cycle. A byte held by downstream back-pressure is
  // not a stall, so the timeout never fires while the output register is full.
  assign timeout_hit = (state_q != S_IDLE) && !accept && !data_valid_q &&
                       (tmo_cnt_q == TIMEOUT_CYCLES - 1);

  // Count stalled mid-packet cycles; any accept, IDLE, or an abort restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_IDLE || accept || timeout_hit) begin
      tmo_cnt_q <= '0;
    end else if (!data_valid_q) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Packet FSM with registered header, payload and error outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      opcode_pend_q <= '0;
      opcode_q      <= '0;
      len_lo_q      <= '0;
      payload_len_q <= '0;
      remaining_q   <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      hdr_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // A pop empties the register unless a payload accept below reloads it.
      if (pop) begin
        data_valid_q <= 1'b0;
      end
      if (timeout_hit) begin
        err_q       <= 1'b1;
        err_code_q  <= 2'b10;
        remaining_q <= '0;
        state_q     <= S_IDLE;
      end else if (accept) begin
        case (state_q)
          S_IDLE: begin
            // Held aside so opcode_o keeps the previous header until this one completes.
            opcode_pend_q <= rx_data_i;
            state_q       <= S_RSVD;
          end
          S_RSVD: begin
            state_q <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo_q <= rx_data_i;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_full < 16'd4) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
              state_q    <= S_IDLE;
            end else begin
              hdr_valid_q   <= 1'b1;
              opcode_q      <= opcode_pend_q;
              payload_len_q <= len_full - 16'd4;
              if (len_full == 16'd4) begin
                state_q <= S_IDLE;
              end else begin
                remaining_q <= len_full - 16'd4;
                state_q     <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            data_q       <= rx_data_i;
            data_valid_q <= 1'b1;
            data_last_q  <= (remaining_q == 16'd1);
            remaining_q  <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_ready_o    = rx_ready;
  assign hdr_valid_o   = hdr_valid_q;
  assign opcode_o      = opcode_q;
  assign payload_len_o = payload_len_q;
  assign data_o        = data_q;
  assign data_valid_o  = data_valid_q;
  assign data_last_o   = data_last_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule
